// File: rtl/scan_unload_ctrl.sv
// Scan chain swap controller: serialises host load words into the chain head
// while capturing the chain tail into unload words, one word at a time.
module scan_unload_ctrl #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic              scan_en_o,
    output logic              scan_in_o,
    input  logic              scan_out_i
);

    localparam int LW = $clog2(CHAIN_LEN + 1);
    localparam int IW = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] sreg;       // load bits still waiting to go out
    logic [WORD_W-1:0] cap;        // unload bits captured so far
    logic [WORD_W-1:0] cap_next;
    logic [LW-1:0]     bits_left;  // chain bits not yet shifted in this swap
    logic [IW-1:0]     bit_idx;    // position within the current word
    logic              last_bit;

    // The current shift cycle is the final one of this word, either because the
    // word is full or because the chain runs out (short last word).
    assign last_bit = (bit_idx == IW'(WORD_W - 1)) || (bits_left == LW'(1));

    // Tail sample lands in the capture bit selected by bit_idx.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_W; gi++) begin : g_cap
            assign cap_next[gi] = (bit_idx == IW'(gi)) ? scan_out_i : cap[gi];
        end
    endgenerate

    assign rdata_o = cap;

    // Swap sequencer; every host/chain-facing output is a flop updated with
    // the state transition so nothing glitches toward the scanned design.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            cap       <= '0;
            bits_left <= '0;
            bit_idx   <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            wready_o  <= 1'b0;
            rvalid_o  <= 1'b0;
            scan_en_o <= 1'b0;
            scan_in_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state     <= LOAD;
                        busy_o    <= 1'b1;
                        wready_o  <= 1'b1;
                        bits_left <= LW'(CHAIN_LEN);
                    end
                end
                LOAD: begin
                    if (wvalid_i) begin
                        // scan_in_o carries the head bit; sreg keeps the rest
                        scan_in_o <= wdata_i[0];
                        sreg      <= wdata_i >> 1;
                        cap       <= '0;
                        bit_idx   <= '0;
                        wready_o  <= 1'b0;
                        scan_en_o <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    cap       <= cap_next;
                    bit_idx   <= bit_idx + IW'(1);
                    bits_left <= bits_left - LW'(1);
                    scan_in_o <= sreg[0];
                    sreg      <= sreg >> 1;
                    if (last_bit) begin
                        scan_en_o <= 1'b0;
                        scan_in_o <= 1'b0;
                        rvalid_o  <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (rready_i) begin
                        rvalid_o <= 1'b0;
                        if (bits_left == '0) begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            wready_o <= 1'b1;
                            state    <= LOAD;
                        end
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_unload_ctrl.sv
// Bench for scan_unload_ctrl: a 64-bit and a 40-bit chain instance share one
// host interface; sel routes the host to one of them at a time.
module tb_scan_unload_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        start = 1'b0;
    logic        wvalid = 1'b0;
    logic        rready = 1'b0;
    logic [31:0] wdata = '0;

    logic        a_busy, a_done, a_wready, a_rvalid, a_scan_en, a_scan_in;
    logic        b_busy, b_done, b_wready, b_rvalid, b_scan_en, b_scan_in;
    logic [31:0] a_rdata, b_rdata;

    logic [63:0] chain_a, chain_a_init;
    logic [39:0] chain_b, chain_b_init;
    logic        chain_set = 1'b0;

    scan_unload_ctrl #(.CHAIN_LEN(64), .WORD_W(32)) dut_a (
        .clk(clk), .rst(rst), .start_i(start & ~sel), .busy_o(a_busy), .done_o(a_done),
        .wdata_i(wdata), .wvalid_i(wvalid & ~sel), .wready_o(a_wready),
        .rdata_o(a_rdata), .rvalid_o(a_rvalid), .rready_i(rready & ~sel),
        .scan_en_o(a_scan_en), .scan_in_o(a_scan_in), .scan_out_i(chain_a[0])
    );

    scan_unload_ctrl #(.CHAIN_LEN(40), .WORD_W(32)) dut_b (
        .clk(clk), .rst(rst), .start_i(start & sel), .busy_o(b_busy), .done_o(b_done),
        .wdata_i(wdata), .wvalid_i(wvalid & sel), .wready_o(b_wready),
        .rdata_o(b_rdata), .rvalid_o(b_rvalid), .rready_i(rready & sel),
        .scan_en_o(b_scan_en), .scan_in_o(b_scan_in), .scan_out_i(chain_b[0])
    );

    wire        busy    = sel ? b_busy    : a_busy;
    wire        done    = sel ? b_done    : a_done;
    wire        wready  = sel ? b_wready  : a_wready;
    wire        rvalid  = sel ? b_rvalid  : a_rvalid;
    wire        scan_en = sel ? b_scan_en : a_scan_en;
    wire [31:0] rdata   = sel ? b_rdata   : a_rdata;

    // Scan chain models: shift toward bit 0, tail is bit 0, head is the MSB.
    always @(posedge clk) begin
        if (chain_set) begin
            chain_a <= chain_a_init;
            chain_b <= chain_b_init;
        end else begin
            if (a_scan_en) chain_a <= {a_scan_in, chain_a[63:1]};
            if (b_scan_en) chain_b <= {b_scan_in, chain_b[39:1]};
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int en_cnt, done_cyc, ndone;
    logic [31:0] rd [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_chains(input logic [63:0] ia, input logic [39:0] ib);
        chain_a_init = ia;
        chain_b_init = ib;
        chain_set = 1'b1;
        @(negedge clk);
        chain_set = 1'b0;
    endtask

    // One full swap on the selected instance with optional load delay,
    // unload stall and spurious start pulses. Called at a negedge.
    task automatic do_swap(input logic use_b, input int wdelay, input int rstall,
                           input logic spur, input logic [31:0] w0, input logic [31:0] w1);
        int wcnt, rcnt, wi, ri;
        logic prev_done;
        logic [31:0] held;
        logic [31:0] ld [2];
        ld[0] = w0; ld[1] = w1;
        wcnt = 0; rcnt = 0; wi = 0; ri = 0; prev_done = 1'b0; held = '0;
        en_cnt = 0; done_cyc = -1; ndone = 0; rd[0] = '0; rd[1] = '0;
        sel = use_b;
        start = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = spur && (scan_en || rvalid);
            if (prev_done) begin
                check("busy_after_done", 64'(busy), 64'd0);
                break;
            end
            if (cyc == 1) check("busy_rise", 64'(busy), 64'd1);
            if (scan_en) en_cnt++;
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
                prev_done = 1'b1;
            end
            if (wready) begin
                if (wcnt >= wdelay && wi < 2) begin
                    wvalid = 1'b1; wdata = ld[wi]; wi++; wcnt = 0;
                end else begin
                    wvalid = 1'b0; wcnt++;
                end
            end else wvalid = 1'b0;
            if (rvalid) begin
                if (rcnt == 0) held = rdata;
                else check("rdata_stable", 64'(rdata), 64'(held));
                if (rcnt >= rstall) begin
                    rready = 1'b1;
                    if (ri < 2) rd[ri] = rdata;
                    ri++; rcnt = 0;
                end else begin
                    rready = 1'b0; rcnt++;
                end
            end else rready = 1'b0;
        end
        start = 1'b0; wvalid = 1'b0; rready = 1'b0;
        $display("swap sel=%0d: rd0=%h rd1=%h scan_en_cycles=%0d done_cycle=%0d done_pulses=%0d",
                 use_b, rd[0], rd[1], en_cnt, done_cyc, ndone);
    endtask

    task automatic verify_a(input int exp_done);
        check("rd0", 64'(rd[0]), 64'h0000_0000_CAFE_F00D);
        check("rd1", 64'(rd[1]), 64'h0000_0000_DEAD_BEEF);
        check("chain_a", chain_a, 64'h2222_2222_1111_1111);
        check("scan_en_cycles", 64'(en_cnt), 64'd64);
        check("done_cycle", 64'(done_cyc), 64'(exp_done));
        check("done_pulses", 64'(ndone), 64'd1);
    endtask

    initial begin
        // Reset held with inputs toggling: everything stays at zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'($urandom); wvalid = 1'($urandom); rready = 1'($urandom);
            wdata = $urandom; sel = 1'($urandom);
            #1;
            check("reset_outs_a", 64'({a_busy, a_done, a_wready, a_rvalid, a_scan_en, a_scan_in, a_rdata}), 64'd0);
            check("reset_outs_b", 64'({b_busy, b_done, b_wready, b_rvalid, b_scan_en, b_scan_in, b_rdata}), 64'd0);
        end
        @(negedge clk);
        start = 1'b0; wvalid = 1'b0; rready = 1'b0; wdata = '0; sel = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_busy", 64'({a_busy, b_busy}), 64'd0);
        end

        // Round trip, no stalls.
        set_chains(64'hDEAD_BEEF_CAFE_F00D, 40'hA5_1234_5678);
        do_swap(1'b0, 0, 0, 1'b0, 32'h1111_1111, 32'h2222_2222);
        verify_a(69);

        // Backpressure on both streams: 2 x 5 load waits and 2 x 3 unload waits.
        set_chains(64'hDEAD_BEEF_CAFE_F00D, 40'hA5_1234_5678);
        do_swap(1'b0, 5, 3, 1'b0, 32'h1111_1111, 32'h2222_2222);
        verify_a(85);

        // Short last word on the 40-bit chain.
        set_chains(64'hDEAD_BEEF_CAFE_F00D, 40'hA5_1234_5678);
        do_swap(1'b1, 0, 0, 1'b0, 32'h89AB_CDEF, 32'hFFFF_FF3C);
        check("b_rd0", 64'(rd[0]), 64'h0000_0000_1234_5678);
        check("b_rd1", 64'(rd[1]), 64'h0000_0000_0000_00A5);
        check("chain_b", 64'(chain_b), 64'h0000_003C_89AB_CDEF);
        check("b_scan_en_cycles", 64'(en_cnt), 64'd40);
        check("b_done_cycle", 64'(done_cyc), 64'd45);
        sel = 1'b0;

        // Reset in the middle of the first word's shift.
        set_chains(64'hDEAD_BEEF_CAFE_F00D, 40'hA5_1234_5678);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; wvalid = 1'b1; wdata = 32'h1111_1111;
        en_cnt = 0;
        for (int i = 0; i < 100 && en_cnt < 17; i++) begin
            @(negedge clk);
            if (a_scan_en) en_cnt++;
        end
        check("reach_bit17", 64'(en_cnt), 64'd17);
        #2 rst = 1'b1;
        #1;
        check("rst_scan_en", 64'(a_scan_en), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0; wvalid = 1'b0;
        set_chains(64'hDEAD_BEEF_CAFE_F00D, 40'hA5_1234_5678);
        do_swap(1'b0, 0, 0, 1'b0, 32'h1111_1111, 32'h2222_2222);
        verify_a(69);

        // Start pulses during SHIFT and EMIT must not disturb the swap.
        set_chains(64'hDEAD_BEEF_CAFE_F00D, 40'hA5_1234_5678);
        do_swap(1'b0, 0, 0, 1'b1, 32'h1111_1111, 32'h2222_2222);
        verify_a(69);
        repeat (4) begin
            @(negedge clk);
            check("no_restart", 64'({a_busy, a_done}), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
